// File: rtl/csi2tx_p2b_seq_ctrl.sv
// Pixel-to-byte sequencer: latches the frame data type, drives one converter enable and a registered pixel stream.
// Optional line counter / YUV420 line-length check is built when CSI2TX_P2B_LINE_CNT_EN is defined.
module csi2tx_p2b_seq_ctrl #(
  parameter int PIX_W = 32,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             line_start,
  input  logic [5:0]       data_type,
  input  logic             sensor_pixel_vld,
  input  logic [PIX_W-1:0] sensor_pixel_data,
  output logic [PIX_W-1:0] pixel_data,
  output logic [PIX_W-1:0] pixel_data_d1,
  output logic             pixel_data_vld,
  output logic [CNT_W-1:0] pixel_cnt,
  output logic             sensor_pixel_vld_falling_edge,
  output logic [4:0]       conv_en,
  output logic             yuv420_odd_even,
  output logic             dt_err
`ifdef CSI2TX_P2B_LINE_CNT_EN
  ,
  output logic [15:0]      line_cnt,
  output logic             line_len_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [PIX_W-1:0] r_pixel_data;
  logic [PIX_W-1:0] r_pixel_data_d1;
  logic             r_pixel_data_vld;
  logic [CNT_W-1:0] r_pixel_cnt;
  logic [4:0]       r_conv_en;
  logic             r_dt_err;
  logic             r_odd_even;
  logic [4:0]       w_conv_dec;
  logic             w_dt_bad;
  logic             w_accept;
  logic             w_eol;
  logic             w_yuv;

  always_comb begin
    w_conv_dec = 5'b00000;
    w_dt_bad   = 1'b0;
    case (data_type)
      6'h18:   w_conv_dec = 5'b00001;
      6'h19:   w_conv_dec = 5'b00010;
      6'h2A:   w_conv_dec = 5'b00100;
      6'h2B:   w_conv_dec = 5'b01000;
      6'h2C:   w_conv_dec = 5'b10000;
      default: w_dt_bad   = 1'b1;
    endcase
  end

  // A pixel is taken inside a line, or in the very cycle its line starts.
  assign w_accept = sensor_pixel_vld &&
                    (line_start || (!frame_start && (r_state != S_IDLE)));
  assign w_yuv    = |r_conv_en[1:0];

  // FLUSH is a one-cycle grace: valid returning there continues the line, otherwise the line ends.
  always_comb begin
    w_state_next = r_state;
    w_eol        = 1'b0;
    if (line_start) begin
      w_state_next = S_ACTIVE;
    end else if (frame_start) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_ACTIVE: begin
          if (r_pixel_data_vld && !sensor_pixel_vld) w_state_next = S_FLUSH;
        end
        S_FLUSH: begin
          w_state_next = sensor_pixel_vld ? S_ACTIVE : S_IDLE;
          w_eol        = !sensor_pixel_vld;
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_pixel_data     <= '0;
      r_pixel_data_d1  <= '0;
      r_pixel_data_vld <= 1'b0;
      r_pixel_cnt      <= '0;
      r_conv_en        <= 5'b00000;
      r_dt_err         <= 1'b0;
      r_odd_even       <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_pixel_data_vld <= w_accept;
      if (w_accept) begin
        r_pixel_data    <= sensor_pixel_data;
        r_pixel_data_d1 <= r_pixel_data;
      end
      if (line_start) begin
        r_pixel_cnt <= '0;
      end else if (r_pixel_data_vld) begin
        r_pixel_cnt <= r_pixel_cnt + CNT_W'(1);
      end
      if (frame_start) begin
        r_conv_en  <= w_conv_dec;
        r_dt_err   <= w_dt_bad;
        r_odd_even <= 1'b0;
      end else if (w_eol && w_yuv) begin
        r_odd_even <= ~r_odd_even;
      end
    end
  end

  assign pixel_data                    = r_pixel_data;
  assign pixel_data_d1                 = r_pixel_data_d1;
  assign pixel_data_vld                = r_pixel_data_vld;
  assign pixel_cnt                     = r_pixel_cnt;
  assign sensor_pixel_vld_falling_edge = w_eol;
  assign conv_en                       = r_conv_en;
  assign yuv420_odd_even               = r_odd_even;
  assign dt_err                        = r_dt_err;

`ifdef CSI2TX_P2B_LINE_CNT_EN
  logic [15:0]      r_line_cnt;
  logic [CNT_W-1:0] r_odd_len;
  logic             r_line_len_err;

  // Odd-line length is remembered so the following even line can be compared against it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_cnt     <= 16'd0;
      r_odd_len      <= '0;
      r_line_len_err <= 1'b0;
    end else begin
      r_line_len_err <= 1'b0;
      if (frame_start) begin
        r_line_cnt <= 16'd0;
      end else if (w_eol) begin
        r_line_cnt <= r_line_cnt + 16'd1;
        if (w_yuv && !r_odd_even) r_odd_len <= r_pixel_cnt;
        if (w_yuv && r_odd_even)  r_line_len_err <= (r_pixel_cnt != r_odd_len);
      end
    end
  end

  assign line_cnt     = r_line_cnt;
  assign line_len_err = r_line_len_err;
`endif

endmodule

// File: tb/tb_csi2tx_p2b_seq_ctrl.sv
// Self-checking bench for csi2tx_p2b_seq_ctrl: directed scenarios plus random traffic against a line-level reference model.
module tb_csi2tx_p2b_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fs, ls, vld;
  logic [5:0]  dt;
  logic [31:0] din;
  logic [31:0] pixel_data, pixel_data_d1;
  logic        pixel_data_vld, eol, yuv420_odd_even, dt_err;
  logic [3:0]  pixel_cnt;
  logic [4:0]  conv_en;

  csi2tx_p2b_seq_ctrl #(.PIX_W(32), .CNT_W(4)) dut (
    .clk                           (clk),
    .rst_n                         (rst_n),
    .frame_start                   (fs),
    .line_start                    (ls),
    .data_type                     (dt),
    .sensor_pixel_vld              (vld),
    .sensor_pixel_data             (din),
    .pixel_data                    (pixel_data),
    .pixel_data_d1                 (pixel_data_d1),
    .pixel_data_vld                (pixel_data_vld),
    .pixel_cnt                     (pixel_cnt),
    .sensor_pixel_vld_falling_edge (eol),
    .conv_en                       (conv_en),
    .yuv420_odd_even               (yuv420_odd_even),
    .dt_err                        (dt_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
  endtask

  // Reference model: line-level view (in a line, waiting one cycle after valid dropped, or idle).
  logic [4:0]  m_conv;
  logic        m_err, m_par, m_in_line, m_wait_end, m_pdv;
  logic [31:0] m_pd, m_pd1;
  int          m_cnt;

  // Per-scenario observations of the DUT.
  int          q_cnt[$];
  logic [31:0] q_pd[$];
  logic [31:0] q_pd1[$];
  int          n_pulse;
  int          pulse_cnt;

  function automatic logic [4:0] dt_map(input logic [5:0] t);
    case (t)
      6'h18:   return 5'b00001;
      6'h19:   return 5'b00010;
      6'h2A:   return 5'b00100;
      6'h2B:   return 5'b01000;
      6'h2C:   return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic model_reset();
    m_conv = '0; m_err = 0; m_par = 0; m_in_line = 0; m_wait_end = 0;
    m_pdv = 0; m_pd = '0; m_pd1 = '0; m_cnt = 0;
  endtask

  task automatic scen_clear();
    q_cnt.delete(); q_pd.delete(); q_pd1.delete();
    n_pulse = 0; pulse_cnt = -1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pdv"},  32'(pixel_data_vld), 32'd0);
    check({tag, "_pd"},   pixel_data, 32'd0);
    check({tag, "_pd1"},  pixel_data_d1, 32'd0);
    check({tag, "_cnt"},  32'(pixel_cnt), 32'd0);
    check({tag, "_eol"},  32'(eol), 32'd0);
    check({tag, "_conv"}, 32'(conv_en), 32'd0);
    check({tag, "_par"},  32'(yuv420_odd_even), 32'd0);
    check({tag, "_err"},  32'(dt_err), 32'd0);
  endtask

  // One clock cycle: drive inputs, compare every output to the model, then advance the model.
  task automatic cyc(input bit f, input bit l, input logic [5:0] d, input bit v, input logic [31:0] x);
    logic exp_eol, accept, fell, yuv;
    @(negedge clk);
    fs = f; ls = l; dt = d; vld = v; din = x;
    #1;
    exp_eol = m_wait_end && !v && !l && !f;
    check("pdv",  32'(pixel_data_vld), 32'(m_pdv));
    check("pd",   pixel_data, m_pd);
    check("pd1",  pixel_data_d1, m_pd1);
    check("cnt",  32'(pixel_cnt), 32'(m_cnt));
    check("eol",  32'(eol), 32'(exp_eol));
    check("conv", 32'(conv_en), 32'(m_conv));
    check("par",  32'(yuv420_odd_even), 32'(m_par));
    check("dterr", 32'(dt_err), 32'(m_err));
    if (pixel_data_vld) begin
      q_cnt.push_back(int'(pixel_cnt));
      q_pd.push_back(pixel_data);
      q_pd1.push_back(pixel_data_d1);
    end
    if (eol) begin
      n_pulse++;
      pulse_cnt = int'(pixel_cnt);
    end
    accept = v && (l || (!f && m_in_line));
    fell   = m_in_line && !m_wait_end && m_pdv && !v;
    yuv    = (m_conv == 5'b00001) || (m_conv == 5'b00010);
    m_cnt  = l ? 0 : (m_pdv ? (m_cnt + 1) % 16 : m_cnt);
    if (accept) begin
      m_pd1 = m_pd;
      m_pd  = x;
    end
    m_pdv = accept;
    if (f) m_par = 0;
    else if (exp_eol && yuv) m_par = ~m_par;
    if (f) begin
      m_conv = dt_map(d);
      m_err  = (dt_map(d) == 5'b00000);
    end
    if (l) begin
      m_in_line = 1; m_wait_end = 0;
    end else if (f) begin
      m_in_line = 0; m_wait_end = 0;
    end else if (m_wait_end) begin
      m_wait_end = 0; m_in_line = v;
    end else if (fell) begin
      m_wait_end = 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 6'h00, 0, 32'h0);
  endtask

  logic [5:0]  dts [5] = '{6'h18, 6'h19, 6'h2A, 6'h2B, 6'h2C};
  logic [31:0] w_a, w_b, w_c;

  initial begin
    rst_n = 0; fs = 0; ls = 0; dt = '0; vld = 0; din = '0;
    model_reset();
    scen_clear();
    #2;
    check_all_zero("reset");
    @(posedge clk); #1 rst_n = 1;

    // RAW10 frame, one 5-pixel line
    scen_clear();
    cyc(1, 0, 6'h2B, 0, 0);
    cyc(0, 1, 6'h00, 0, 0);
    check("raw10_conv", 32'(conv_en), 32'h08);
    for (int i = 0; i < 5; i++) cyc(0, 0, 6'h00, 1, $urandom);
    idle(4);
    check("raw10_npix", q_cnt.size(), 5);
    for (int i = 0; i < q_cnt.size(); i++) check("raw10_idx", q_cnt[i], i);
    check("raw10_npulse", n_pulse, 1);
    check("raw10_pulsecnt", pulse_cnt, 5);
    $display("txn raw10 line: pixels=%0d pulses=%0d cnt_at_pulse=%0d", q_cnt.size(), n_pulse, pulse_cnt);

    // YUV420 10b frame, three 20-pixel lines
    cyc(1, 0, 6'h19, 0, 0);
    scen_clear();
    for (int ln = 0; ln < 3; ln++) begin
      q_cnt.delete();
      cyc(0, 1, 6'h00, 0, 0);
      check("yuv_parity", 32'(yuv420_odd_even), 32'(ln % 2));
      for (int i = 0; i < 20; i++) cyc(0, 0, 6'h00, 1, $urandom);
      idle(4);
      check("yuv_wrap15", q_cnt[15], 15);
      check("yuv_wrap0", q_cnt[16], 0);
      check("yuv_pulsecnt", pulse_cnt, 4);
      check("yuv_npulse", n_pulse, ln + 1);
      $display("txn yuv line %0d: pixels=%0d cnt_at_pulse=%0d", ln, q_cnt.size(), pulse_cnt);
    end

    // Unsupported type, then recovery
    cyc(1, 0, 6'h3F, 0, 0);
    idle(1);
    check("bad_conv", 32'(conv_en), 32'h00);
    check("bad_err", 32'(dt_err), 32'h1);
    cyc(1, 0, 6'h18, 0, 0);
    idle(1);
    check("rec_conv", 32'(conv_en), 32'h01);
    check("rec_err", 32'(dt_err), 32'h0);
    $display("txn dt recovery: conv_en=%b dt_err=%0d", conv_en, dt_err);

    // Single-cycle gap inside a line
    scen_clear();
    w_a = $urandom; w_b = $urandom; w_c = $urandom;
    cyc(0, 1, 6'h00, 0, 0);
    cyc(0, 0, 6'h00, 1, w_a);
    cyc(0, 0, 6'h00, 0, 32'h0);
    cyc(0, 0, 6'h00, 1, w_b);
    cyc(0, 0, 6'h00, 1, w_c);
    idle(4);
    check("gap_npix", q_cnt.size(), 3);
    if (q_cnt.size() == 3) begin
      check("gap_b", q_pd[1], w_b);
      check("gap_b_d1", q_pd1[1], w_a);
      check("gap_c_d1", q_pd1[2], w_b);
      check("gap_c_idx", q_cnt[2], 2);
    end
    check("gap_npulse", n_pulse, 1);
    check("gap_pulsecnt", pulse_cnt, 3);
    $display("txn gap line: pixels=%0d pulses=%0d", q_cnt.size(), n_pulse);

    // line_start mid-line after 7 pixels
    scen_clear();
    cyc(0, 1, 6'h00, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 6'h00, 1, $urandom);
    cyc(0, 1, 6'h00, 1, $urandom);
    for (int i = 0; i < 3; i++) cyc(0, 0, 6'h00, 1, $urandom);
    idle(4);
    check("restart_idx", q_cnt[7], 0);
    check("restart_npulse", n_pulse, 1);
    check("restart_pulsecnt", pulse_cnt, 4);
    $display("txn restart line: pixels=%0d pulses=%0d", q_cnt.size(), n_pulse);

    // Asynchronous reset while a line is active
    cyc(0, 1, 6'h00, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 6'h00, 1, $urandom);
    @(negedge clk);
    vld = 1; din = $urandom;
    #1 rst_n = 0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(posedge clk); #1 rst_n = 1;
    scen_clear();
    for (int i = 0; i < 5; i++) cyc(0, 0, 6'h00, 1, $urandom);
    check("postrst_drop", q_cnt.size(), 0);
    cyc(1, 1, 6'h2A, 1, $urandom);
    idle(3);
    check("postrst_conv", 32'(conv_en), 32'h04);
    check("postrst_idx0", q_cnt.size() > 0 ? q_cnt[0] : -1, 0);
    $display("txn async reset: dropped_then_pixels=%0d conv_en=%b", q_cnt.size(), conv_en);

    // Random traffic
    begin
      bit mode = 0;
      logic [5:0] d;
      int r;
      for (int i = 0; i < 3000; i++) begin
        r = $urandom % 8;
        d = (r < 5) ? dts[r] : 6'($urandom);
        if (($urandom % 10) == 0) mode = ~mode;
        cyc(($urandom % 64) == 0, ($urandom % 20) == 0, d, mode, $urandom);
      end
      $display("txn random: 3000 cycles, %0d checks so far", n_chk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
